// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector-write scheduler.
// State encodings and the default sector size in 16-bit words.
package sd_pkg;

    localparam logic [2:0] ENC_IDLE        = 3'd0;
    localparam logic [2:0] ENC_WAIT_DATA   = 3'd1;
    localparam logic [2:0] ENC_START       = 3'd2;
    localparam logic [2:0] ENC_WAIT_BUSY_H = 3'd3;
    localparam logic [2:0] ENC_WAIT_BUSY_L = 3'd4;
    localparam logic [2:0] ENC_NEXT        = 3'd5;
    localparam logic [2:0] ENC_DONE        = 3'd6;
    localparam logic [2:0] ENC_ERR         = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE        = ENC_IDLE,
        S_WAIT_DATA   = ENC_WAIT_DATA,
        S_START       = ENC_START,
        S_WAIT_BUSY_H = ENC_WAIT_BUSY_H,
        S_WAIT_BUSY_L = ENC_WAIT_BUSY_L,
        S_NEXT        = ENC_NEXT,
        S_DONE        = ENC_DONE,
        S_ERR         = ENC_ERR
    } state_e;

    localparam logic [11:0] SEC_WORDS_DEF = 12'd256;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both stages clear to 0 on reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sd_wr_sched.sv
// Schedules consecutive SD sector writes for one recording run,
// gating each start on FIFO fill and tracking writer busy handshakes.
module sd_wr_sched
    import sd_pkg::*;
#(
    parameter logic [31:0] START_SECTOR = 32'd2048,
    parameter logic [15:0] NUM_SECTORS  = 16'd3,
    parameter logic [11:0] SEC_WORDS    = SEC_WORDS_DEF,
    parameter logic [7:0]  BUSY_TMO     = 8'd64
) (
    input  logic        wr_clk,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        run_req,
    input  logic [11:0] fifo_level,
    input  logic        sd_wr_busy,
    output logic        sd_wr_start,
    output logic [31:0] sd_wr_sec_addr,
    output logic [15:0] sec_done_cnt,
    output logic        run_done,
    output logic        err_tmo
);

    logic init_s;
    logic busy_s;

    sync_2ff u_sync_init (
        .clk_i (wr_clk),
        .rst_n (rst_n),
        .d_i   (sd_init_done),
        .q_o   (init_s)
    );

    sync_2ff u_sync_busy (
        .clk_i (wr_clk),
        .rst_n (rst_n),
        .d_i   (sd_wr_busy),
        .q_o   (busy_s)
    );

    state_e      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;

        // Losing card init abandons the run but keeps the progress count.
        if (!init_s && state_q != S_ERR) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (init_s && run_req && !busy_s) begin
                        cnt_d  = '0;
                        addr_d = START_SECTOR;
                        if (NUM_SECTORS == 16'd0)
                            state_d = S_DONE;
                        else
                            state_d = S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (fifo_level >= SEC_WORDS && !busy_s)
                        state_d = S_START;
                end
                S_START: begin
                    tmo_d   = '0;
                    state_d = S_WAIT_BUSY_H;
                end
                S_WAIT_BUSY_H: begin
                    if (busy_s)
                        state_d = S_WAIT_BUSY_L;
                    else if (tmo_q == BUSY_TMO - 8'd1)
                        state_d = S_ERR;
                    else
                        tmo_d = tmo_q + 8'd1;
                end
                S_WAIT_BUSY_L: begin
                    if (!busy_s)
                        state_d = S_NEXT;
                end
                S_NEXT: begin
                    cnt_d  = cnt_q + 16'd1;
                    addr_d = addr_q + 32'd1;
                    if (cnt_q + 16'd1 == NUM_SECTORS)
                        state_d = S_DONE;
                    else
                        state_d = S_WAIT_DATA;
                end
                S_DONE: begin
                    if (!run_req)
                        state_d = S_IDLE;
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        start_d = (state_d == S_START);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= START_SECTOR;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign sd_wr_start    = start_q;
    assign sd_wr_sec_addr = addr_q;
    assign sec_done_cnt   = cnt_q;
    assign run_done       = done_q;
    assign err_tmo        = err_q;

endmodule

// File: tb/tb_sd_wr_sched.sv
// Directed bench for sd_wr_sched with an SD-writer responder
// and a per-cycle checker of run-level rules.
module tb_sd_wr_sched;

    localparam logic [31:0] START = 32'd2048;
    localparam logic [15:0] NUM   = 16'd3;
    localparam int          TMO   = 64;

    logic        wr_clk;
    logic        rst_n;
    logic        sd_init_done;
    logic        run_req;
    logic [11:0] fifo_level;
    logic        sd_wr_busy;
    logic        sd_wr_start;
    logic [31:0] sd_wr_sec_addr;
    logic [15:0] sec_done_cnt;
    logic        run_done;
    logic        err_tmo;

    int vectors = 0;
    int miscompares = 0;
    bit wr_resp = 1'b1;

    sd_wr_sched dut (
        .wr_clk         (wr_clk),
        .rst_n          (rst_n),
        .sd_init_done   (sd_init_done),
        .run_req        (run_req),
        .fifo_level     (fifo_level),
        .sd_wr_busy     (sd_wr_busy),
        .sd_wr_start    (sd_wr_start),
        .sd_wr_sec_addr (sd_wr_sec_addr),
        .sec_done_cnt   (sec_done_cnt),
        .run_done       (run_done),
        .err_tmo        (err_tmo)
    );

    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #2;
    endtask

    // Writer model: busy rises 2 cycles after a start, stays up 10 cycles.
    initial begin
        sd_wr_busy = 1'b0;
        forever begin
            @(negedge wr_clk);
            if (sd_wr_start && wr_resp) begin
                repeat (2) @(negedge wr_clk);
                sd_wr_busy = 1'b1;
                repeat (10) @(negedge wr_clk);
                sd_wr_busy = 1'b0;
            end
        end
    end

    // Bench view of the busy level the scheduler can have seen.
    logic b1, b2, b3;
    always @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            b1 <= 1'b0;
            b2 <= 1'b0;
            b3 <= 1'b0;
        end else begin
            b1 <= sd_wr_busy;
            b2 <= b1;
            b3 <= b2;
        end
    end

    // Run-level rules that must hold on every cycle out of reset.
    initial begin
        logic        pv_start;
        logic        pv_err;
        logic [15:0] pv_cnt;
        bit          pv_ok;
        pv_ok = 1'b0;
        pv_start = 1'b0;
        pv_err = 1'b0;
        pv_cnt = '0;
        forever begin
            @(negedge wr_clk);
            if (!rst_n) begin
                pv_ok = 1'b0;
            end else begin
                chk("inv_addr", sd_wr_sec_addr, START + {16'd0, sec_done_cnt});
                chk("inv_done", {31'd0, run_done && sec_done_cnt != NUM}, 0);
                chk("inv_start_busy", {31'd0, sd_wr_start && b3}, 0);
                chk("inv_err_start", {31'd0, sd_wr_start && err_tmo}, 0);
                if (pv_ok) begin
                    chk("inv_pulse", {31'd0, sd_wr_start && pv_start}, 0);
                    chk("inv_sticky", {31'd0, pv_err && !err_tmo}, 0);
                    chk("inv_cnt_step",
                        {31'd0, !(sec_done_cnt == pv_cnt ||
                                  sec_done_cnt == pv_cnt + 16'd1 ||
                                  sec_done_cnt == 16'd0)}, 0);
                end
                pv_start = sd_wr_start;
                pv_err = err_tmo;
                pv_cnt = sec_done_cnt;
                pv_ok = 1'b1;
            end
        end
    end

    task automatic wait_start(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (sd_wr_start) seen = 1'b1;
        end
    endtask

    task automatic wait_busy(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (sd_wr_busy) seen = 1'b1;
        end
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 200 && sd_wr_busy; i++) tick();
        chk("quiet_busy", {31'd0, sd_wr_busy}, 0);
        repeat (4) tick();
    endtask

    task automatic run_to_done(input int max, output int starts,
                               output bit done);
        starts = 0;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            tick();
            if (sd_wr_start) starts++;
            if (run_done) done = 1'b1;
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_start"}, {31'd0, sd_wr_start}, 0);
        chk({nm, "_addr"}, sd_wr_sec_addr, START);
        chk({nm, "_cnt"}, {16'd0, sec_done_cnt}, 0);
        chk({nm, "_done"}, {31'd0, run_done}, 0);
        chk({nm, "_err"}, {31'd0, err_tmo}, 0);
    endtask

    initial begin
        logic [31:0] addrs[$];
        bit          seen;
        bit          done;
        int          n;
        int          k;

        rst_n = 1'b0;
        sd_init_done = 1'b0;
        run_req = 1'b0;
        fifo_level = 12'd0;
        repeat (3) tick();
        chk_reset_vals("rst0");
        rst_n = 1'b1;
        repeat (3) tick();

        // Normal three-sector run.
        sd_init_done = 1'b1;
        fifo_level = 12'd300;
        run_req = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            tick();
            if (sd_wr_start) addrs.push_back(sd_wr_sec_addr);
            if (run_done) done = 1'b1;
        end
        chk("n1_starts", addrs.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("n1_addr", i < addrs.size() ? addrs[i] : 32'hFFFF_FFFF,
                START + i);
        chk("n1_done", {31'd0, run_done}, 1);
        chk("n1_cnt", {16'd0, sec_done_cnt}, 3);
        repeat (5) tick();
        chk("n1_hold_done", {31'd0, run_done}, 1);
        run_req = 1'b0;
        repeat (2) tick();
        chk("n1_idle_done", {31'd0, run_done}, 0);
        chk("n1_cnt_keep", {16'd0, sec_done_cnt}, 3);
        chk("n1_addr_keep", sd_wr_sec_addr, START + 3);
        wait_quiet();

        // run_req dropped right after the first start.
        run_req = 1'b1;
        wait_start(100, seen);
        chk("r2_first", {31'd0, seen}, 1);
        chk("r2_addr0", sd_wr_sec_addr, START);
        chk("r2_cnt0", {16'd0, sec_done_cnt}, 0);
        run_req = 1'b0;
        run_to_done(600, n, done);
        chk("r2_more_starts", n, 2);
        chk("r2_done", {31'd0, done}, 1);
        tick();
        chk("r2_back_idle", {31'd0, run_done}, 0);
        chk("r2_cnt", {16'd0, sec_done_cnt}, 3);
        wait_quiet();

        // Starvation one word below a full sector.
        fifo_level = 12'd255;
        run_req = 1'b1;
        n = 0;
        repeat (1000) begin
            tick();
            if (sd_wr_start) n++;
        end
        chk("s3_nostart", n, 0);
        fifo_level = 12'd256;
        wait_start(4, seen);
        chk("s3_start", {31'd0, seen}, 1);
        chk("s3_addr", sd_wr_sec_addr, START);
        run_to_done(600, n, done);
        chk("s3_done", {31'd0, done}, 1);
        run_req = 1'b0;
        fifo_level = 12'd300;
        wait_quiet();

        // Card init lost while sector 2 is busy.
        run_req = 1'b1;
        wait_start(100, seen);
        wait_start(100, seen);
        chk("i4_second", {31'd0, seen}, 1);
        chk("i4_addr", sd_wr_sec_addr, START + 1);
        wait_busy(50, seen);
        chk("i4_busy", {31'd0, seen}, 1);
        repeat (4) tick();
        sd_init_done = 1'b0;
        repeat (4) tick();
        chk("i4_cnt", {16'd0, sec_done_cnt}, 1);
        chk("i4_done", {31'd0, run_done}, 0);
        n = 0;
        repeat (60) begin
            tick();
            if (sd_wr_start) n++;
        end
        chk("i4_nostart", n, 0);
        chk("i4_cnt_hold", {16'd0, sec_done_cnt}, 1);
        run_req = 1'b0;
        sd_init_done = 1'b1;
        wait_quiet();

        // Reset while the writer is busy.
        run_req = 1'b1;
        wait_start(100, seen);
        chk("m5_start", {31'd0, seen}, 1);
        wait_busy(50, seen);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk_reset_vals("m5");
        repeat (15) tick();
        run_req = 1'b0;
        rst_n = 1'b1;
        n = 0;
        repeat (30) begin
            tick();
            if (sd_wr_start) n++;
        end
        chk("m5_noretry", n, 0);
        chk("m5_addr", sd_wr_sec_addr, START);
        wait_quiet();

        // Writer never responds: timeout.
        wr_resp = 1'b0;
        run_req = 1'b1;
        wait_start(100, seen);
        chk("t6_start", {31'd0, seen}, 1);
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            k++;
            if (err_tmo) seen = 1'b1;
        end
        chk("t6_err", {31'd0, seen}, 1);
        // Pulse cycle, then 64 cycles without busy before the error shows.
        chk("t6_latency", k, TMO + 1);
        n = 0;
        repeat (200) begin
            tick();
            if (sd_wr_start) n++;
        end
        chk("t6_nostart", n, 0);
        chk("t6_sticky", {31'd0, err_tmo}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_err", {31'd0, err_tmo}, 0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
